// File: rtl/max_pool_2x2.sv
// Streaming 2x2 / stride-2 signed max-pool over a raster-order feature map.
// A hold register pairs columns; a half-width line buffer carries the even-row pair max down.
module max_pool_2x2 #(
  parameter int FEATURE_WIDTH = 32,
  parameter int MAP_WIDTH     = 16,
  parameter int MAP_HEIGHT    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_clr,
  input  logic                     in_valid,
  input  logic [FEATURE_WIDTH-1:0] in_data,
  output logic                     out_valid,
  output logic [FEATURE_WIDTH-1:0] out_data,
  output logic                     frame_done
);
  localparam int CW   = $clog2(MAP_WIDTH);
  localparam int RW   = $clog2(MAP_HEIGHT);
  localparam int LB_N = MAP_WIDTH / 2;
  localparam int AW   = (LB_N > 1) ? $clog2(LB_N) : 1;

  logic [CW-1:0]                   r_col;
  logic [RW-1:0]                   r_row;
  logic signed [FEATURE_WIDTH-1:0] r_h;
  logic signed [FEATURE_WIDTH-1:0] r_lb [LB_N];
  logic                            r_out_valid;
  logic [FEATURE_WIDTH-1:0]        r_out_data;
  logic                            r_frame_done;

  logic                            w_acc;
  logic                            w_col_last;
  logic                            w_row_last;
  logic [AW-1:0]                   w_idx;
  logic signed [FEATURE_WIDTH-1:0] w_in;
  logic signed [FEATURE_WIDTH-1:0] w_lb_rd;
  logic signed [FEATURE_WIDTH-1:0] w_pair;
  logic signed [FEATURE_WIDTH-1:0] w_quad;

  assign w_acc      = in_valid & ~frame_clr;
  assign w_col_last = (r_col == CW'(MAP_WIDTH - 1));
  assign w_row_last = (r_row == RW'(MAP_HEIGHT - 1));
  assign w_idx      = AW'(r_col >> 1);
  assign w_in       = $signed(in_data);
  assign w_lb_rd    = r_lb[w_idx];
  assign w_pair     = (w_in > r_h) ? w_in : r_h;
  assign w_quad     = (w_lb_rd > w_pair) ? w_lb_rd : w_pair;

  // Entries are always rewritten on an even row before the odd row reads them,
  // so the buffer needs no reset or clear.
  always_ff @(posedge clk) begin
    if (w_acc && r_col[0] && !r_row[0])
      r_lb[w_idx] <= w_pair;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_h          <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (frame_clr) begin
        r_col <= '0;
        r_row <= '0;
        r_h   <= '0;
      end else if (in_valid) begin
        if (!r_col[0]) begin
          r_h <= w_in;
        end else if (r_row[0]) begin
          r_out_data   <= w_quad;
          r_out_valid  <= 1'b1;
          r_frame_done <= w_row_last & w_col_last;
        end
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign frame_done = r_frame_done;
endmodule

// File: tb/tb_max_pool_2x2.sv
// Scoreboard bench for max_pool_2x2 on a 4x4 map: expected windows are queued
// at drive time from a full-frame reference and popped when out_valid fires.
module tb_max_pool_2x2;
  localparam int FW = 32;
  localparam int W  = 4;
  localparam int H  = 4;

  typedef struct {
    logic [FW-1:0] data;
    logic          done;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_clr;
  logic          in_valid;
  logic [FW-1:0] in_data;
  logic          out_valid;
  logic [FW-1:0] out_data;
  logic          frame_done;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   fr [W*H];
  exp_t sb [$];

  max_pool_2x2 #(.FEATURE_WIDTH(FW), .MAP_WIDTH(W), .MAP_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .frame_clr(frame_clr), .in_valid(in_valid),
    .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, $signed(got), $signed(exp), $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", {31'b0, out_valid}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("data", out_data, e.data);
          chk("frame_done", {31'b0, frame_done}, {31'b0, e.done});
          chk("latency_cyc", cyc, e.cyc);
        end
      end else if (frame_done) begin
        chk("stray_done", {31'b0, frame_done}, 0);
      end
    end
  end

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid  = 1'b0;
      frame_clr = 1'b0;
    end
  endtask

  // Drive the first n entries of fr; bottom-right of each window queues its expected max.
  task automatic send(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int r, c, m, k;
      k = 0;
      if (gaps)
        while (k < 4 && $urandom_range(1, 0) == 1) begin
          idle(1);
          k++;
        end
      @(negedge clk);
      in_valid  = 1'b1;
      frame_clr = 1'b0;
      in_data   = fr[i];
      r = i / W;
      c = i % W;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        m = mx(mx(fr[(r-1)*W + c-1], fr[(r-1)*W + c]), mx(fr[r*W + c-1], fr[r*W + c]));
        sb.push_back('{data: m, done: (i == W*H-1), cyc: cyc + 1});
      end
    end
  endtask

  task automatic fill_ramp(input int base);
    for (int i = 0; i < W*H; i++) fr[i] = base + i;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"}, {31'b0, out_valid}, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_done"}, {31'b0, frame_done}, 0);
  endtask

  initial begin
    rst = 1'b1; frame_clr = 1'b0; in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    chk_reset_outs("reset");
    @(negedge clk);
    rst = 1'b0;

    // ramp: expect 5, 7, 13, 15 with frame_done on 15
    fill_ramp(0);
    send(W*H, 1'b0);
    idle(2);

    // 100 in each window corner in turn, 1s elsewhere
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < W*H; i++) fr[i] = 1;
      for (int wr = 0; wr < H/2; wr++)
        for (int wc = 0; wc < W/2; wc++)
          fr[(2*wr + k/2)*W + 2*wc + k%2] = 100;
      send(W*H, 1'b0);
    end
    idle(2);

    // signed: -8 field, -3 at a different corner per window
    for (int i = 0; i < W*H; i++) fr[i] = -8;
    for (int j = 0; j < 4; j++)
      fr[(2*(j/2) + j/2)*W + 2*(j%2) + j%2] = -3;
    send(W*H, 1'b0);
    idle(2);

    // ramp with random input gaps
    fill_ramp(0);
    send(W*H, 1'b1);
    idle(2);

    // back-to-back frames: ramp then ramp+16
    fill_ramp(0);
    send(W*H, 1'b0);
    fill_ramp(16);
    send(W*H, 1'b0);
    idle(2);

    // abort a partial frame with a one-cycle reset, then a full ramp
    fill_ramp(0);
    send(6, 1'b0);
    idle(1);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk_reset_outs("midreset");
    @(negedge clk);
    rst = 1'b0;
    fill_ramp(0);
    send(W*H, 1'b0);
    idle(2);

    // abort with frame_clr coincident with a valid input that must be dropped
    fill_ramp(0);
    send(6, 1'b0);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 99;
    frame_clr = 1'b1;
    fill_ramp(0);
    send(W*H, 1'b0);
    idle(6);

    chk("drain_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
